// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, fixed wait states,
// word-addressed register array with byte-lane strobes and out-of-range error.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_error,
  output logic                    busy
);

  // state  | meaning
  // S_IDLE | ready, request accepted and latched on req_valid
  // S_WAIT | counting down WAIT_STATES idle cycles
  // S_RESP | one-cycle response pulse, data/error presented

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           wstrb_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    cur_write;
  logic [DATA_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic [NB-1:0]           cur_wstrb;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    commit;

  // With zero wait states RESP is entered straight from IDLE, so the commit
  // must use the live request rather than the not-yet-latched copy.
  assign cur_write = (state_q == S_IDLE) ? req_write : wr_q;
  assign cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign cur_wstrb = (state_q == S_IDLE) ? req_wstrb : wstrb_q;
  assign in_range  = (cur_addr[DATA_WIDTH-1:DEPTH_LOG2] == '0);
  assign idx       = cur_addr[DEPTH_LOG2-1:0];
  assign commit    = (state_d == S_RESP) && (state_q != S_RESP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        cnt_q   <= 4'(WAIT_STATES);
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      if (cur_write && in_range) begin
        for (int b = 0; b < NB; b++)
          if (cur_wstrb[b]) mem_q[idx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
      end
      rdata_q <= (!cur_write && in_range) ? mem_q[idx] : '0;
      err_q   <= !in_range;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_error = resp_valid & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance and a 0-wait-state instance,
// expected responses queued at request time and compared when resp_valid fires.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        valid0, valid1;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        ready0, rv0, err0, busy0;
  logic [31:0] rd0;
  logic        ready1, rv1, err1, busy1;
  logic [31:0] rd1;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;
  exp_t sb[$];

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .WAIT_STATES(2)) u0 (
    .clk(clk), .rst(rst), .req_valid(valid0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(ready0), .resp_valid(rv0), .resp_rdata(rd0),
    .resp_error(err0), .busy(busy0));

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(ready1), .resp_valid(rv1), .resp_rdata(rd1),
    .resp_error(err1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t pop_exp();
    exp_t e;
    e = '{32'h0, 1'b0, -100};
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int sel, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic push,
                       input logic [31:0] exp_rd, input logic exp_err, output int acc);
    logic rdy;
    acc = -1;
    req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      rdy = (sel == 0) ? ready0 : ready1;
      if (rdy) acc = cyc + 1;
      @(posedge clk);
      @(negedge clk);
    end
    valid0 = 1'b0; valid1 = 1'b0;
    if (acc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL issue_accept: addr %h never accepted, required accept within 20 cycles", a);
    end else if (push) begin
      sb.push_back('{exp_rd, exp_err, acc});
    end
  endtask

  task automatic wait_resp(input int sel, output logic got, output logic [31:0] rd,
                           output logic er, output int cy);
    got = 1'b0; rd = '0; er = 1'b0; cy = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((sel == 0) ? rv0 : rv1) begin
        got = 1'b1;
        rd  = (sel == 0) ? rd0 : rd1;
        er  = (sel == 0) ? err0 : err1;
        cy  = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready0); end
    n_tests++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", rv0); end
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rd0); end
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", err0); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    n_tests++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_ws0: got %b expected 1", ready1); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_latency();
    int acc, cy; logic got, er; logic [31:0] rd; exp_t e;
    issue(0, 1'b0, 32'h3, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, acc);
    n_tests++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL load_ready_drop: got %b expected 0", ready0); end
    n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b expected 1", busy0); end
    wait_resp(0, got, rd, er, cy);
    e = pop_exp();
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL load_timeout: resp_valid got %b expected 1", got); end
    n_tests++; if (cy - e.acc + 1 != 3) begin n_fail++; $display("FAIL load_latency: got %0d cycles expected 3", cy - e.acc + 1); end
    n_tests++; if (rd !== e.rdata) begin n_fail++; $display("FAIL load_rdata: got %h expected %h", rd, e.rdata); end
    n_tests++; if (er !== e.err) begin n_fail++; $display("FAIL load_error: got %b expected %b", er, e.err); end
  endtask

  task automatic test_store_load();
    int acc1, acc2, cy; logic got, er; logic [31:0] rd; exp_t e;
    issue(0, 1'b1, 32'h5, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 1'b0, acc1);
    wait_resp(0, got, rd, er, cy);
    e = pop_exp();
    n_tests++; if (got !== 1'b1 || rd !== e.rdata) begin n_fail++; $display("FAIL store_rdata: got %h (valid %b) expected %h", rd, got, e.rdata); end
    issue(0, 1'b0, 32'h5, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, acc2);
    wait_resp(0, got, rd, er, cy);
    e = pop_exp();
    n_tests++; if (got !== 1'b1 || rd !== e.rdata) begin n_fail++; $display("FAIL store_then_load: got %h (valid %b) expected %h", rd, got, e.rdata); end
    n_tests++; if (acc2 - acc1 != 4) begin n_fail++; $display("FAIL back_to_back_spacing: got %0d expected 4", acc2 - acc1); end
  endtask

  task automatic test_strobe_merge();
    logic        wr [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] wd [3] = '{32'h11223344, 32'hAABBCCDD, 32'h0};
    logic [3:0]  ws [3] = '{4'hF, 4'b0101, 4'h0};
    logic [31:0] ex [3] = '{32'h0, 32'h0, 32'h11BB33DD};
    int acc, cy; logic got, er; logic [31:0] rd; exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(0, wr[i], 32'h7, wd[i], ws[i], 1'b1, ex[i], 1'b0, acc);
      wait_resp(0, got, rd, er, cy);
      e = pop_exp();
      n_tests++; if (got !== 1'b1 || rd !== e.rdata) begin n_fail++; $display("FAIL strobe_rdata[%0d]: got %h (valid %b) expected %h", i, rd, got, e.rdata); end
    end
  endtask

  task automatic test_out_of_range();
    logic        wr [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ad [3] = '{32'h10, 32'h10, 32'h0};
    logic [31:0] wd [3] = '{32'h0, 32'h12345678, 32'h0};
    logic        ee [3] = '{1'b1, 1'b1, 1'b0};
    int acc, cy; logic got, er; logic [31:0] rd; exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(0, wr[i], ad[i], wd[i], 4'hF, 1'b1, 32'h0, ee[i], acc);
      wait_resp(0, got, rd, er, cy);
      e = pop_exp();
      n_tests++; if (got !== 1'b1 || rd !== e.rdata) begin n_fail++; $display("FAIL oor_rdata[%0d]: got %h (valid %b) expected %h", i, rd, got, e.rdata); end
      n_tests++; if (er !== e.err) begin n_fail++; $display("FAIL oor_error[%0d]: got %b expected %b", i, er, e.err); end
    end
  endtask

  task automatic test_reset_abort();
    int acc, cy, pulses; logic got, er; logic [31:0] rd; exp_t e;
    issue(0, 1'b1, 32'h2, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b0, acc);
    rst = 1'b0;
    #1;
    n_tests++; if (busy0 !== 1'b0 || ready0 !== 1'b1) begin n_fail++; $display("FAIL abort_async: busy %b ready %b expected busy 0 ready 1", busy0, ready0); end
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rv0) pulses++;
      @(negedge clk);
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL abort_no_resp: got %0d pulses expected 0", pulses); end
    issue(0, 1'b0, 32'h2, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, acc);
    wait_resp(0, got, rd, er, cy);
    e = pop_exp();
    n_tests++; if (got !== 1'b1 || rd !== e.rdata) begin n_fail++; $display("FAIL abort_load: got %h (valid %b) expected %h", rd, got, e.rdata); end
  endtask

  task automatic test_ws0_stream();
    logic [31:0] val1 = 32'h11110001;
    logic [31:0] val2 = 32'h22220002;
    logic [31:0] a;
    int acc, cy; logic got, er; logic [31:0] rd; exp_t e;
    issue(1, 1'b1, 32'h1, val1, 4'hF, 1'b1, 32'h0, 1'b0, acc);
    wait_resp(1, got, rd, er, cy);
    e = pop_exp();
    n_tests++; if (got !== 1'b1 || cy - e.acc + 1 != 1) begin n_fail++; $display("FAIL ws0_store_latency: got %0d (valid %b) expected 1", cy - e.acc + 1, got); end
    issue(1, 1'b1, 32'h2, val2, 4'hF, 1'b1, 32'h0, 1'b0, acc);
    wait_resp(1, got, rd, er, cy);
    e = pop_exp();
    @(negedge clk);
    a = 32'h1;
    req_write = 1'b0; req_wstrb = 4'h0; req_addr = a; valid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (rv1 !== logic'(i % 2)) begin n_fail++; $display("FAIL ws0_pulse[%0d]: got %b expected %0d", i, rv1, i % 2); end
      if (ready1) sb.push_back('{(a == 32'h1) ? val1 : val2, 1'b0, cyc + 1});
      if (rv1) begin
        e = pop_exp();
        n_tests++; if (rd1 !== e.rdata) begin n_fail++; $display("FAIL ws0_rdata[%0d]: got %h expected %h", i, rd1, e.rdata); end
        n_tests++; if (cyc != e.acc) begin n_fail++; $display("FAIL ws0_latency[%0d]: got accept edge %0d expected %0d", i, e.acc, cyc); end
        a = (a == 32'h1) ? 32'h2 : 32'h1;
        req_addr = a;
      end
      @(negedge clk);
    end
    valid1 = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    test_reset();
    test_load_latency();
    test_store_load();
    test_strobe_merge();
    test_out_of_range();
    test_reset_abort();
    test_ws0_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the mini-RISC data-memory interface. It services load/store requests issued by the core datapath.
- Accepts one request at a time over a valid/ready handshake and holds a word-addressed register array.
- Models a configurable number of wait states, then returns read data or a store acknowledge with an out-of-range error flag.
- Replaces the zero-latency memory so the core and its control unit can be exercised against multi-cycle memory.

Parameters:
- DATA_WIDTH, 32, width of data words and of the request address.
- DEPTH_LOG2, 4, log2 of the number of words in the array (16 words by default).
- WAIT_STATES, 2, number of idle cycles inserted between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  DATA_WIDTH  word address (the ALU result).
- req_wdata  input  DATA_WIDTH  store data (the second register value).
- req_wstrb  input  DATA_WIDTH/8  byte-lane write strobes; bit i enables byte i.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
- resp_error  output  1  address out of range; qualified by resp_valid.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE and the wait counter is cleared.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, busy=0.
  - All array words are cleared to 0.
- States and transitions:
  - IDLE: req_ready=1. On req_valid=1, latch write, addr, wdata and wstrb. Load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else go to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle. When the counter reaches 1, go to RESP next edge, so WAIT lasts exactly WAIT_STATES cycles.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE. req_ready=1 again in the cycle after RESP.
- Latency:
  - resp_valid is high in the (WAIT_STATES+1)-th cycle after the accepting edge.
  - Back-to-back accepts are spaced WAIT_STATES+2 cycles apart.
- Request inputs are sampled only at the accepting edge. Changes while busy are ignored; req_valid held high while busy does not queue a request.
- Address decode:
  - index = addr[DEPTH_LOG2-1:0].
  - The request is in range iff addr[DATA_WIDTH-1:DEPTH_LOG2]==0.
- Store commit:
  - Happens on the edge that enters RESP, never earlier.
  - Only byte lanes with wstrb=1 are written; other lanes keep their value.
  - A store with wstrb=0 is a legal no-op acknowledge.
  - resp_rdata=0 for stores.
- Load: resp_rdata = array[index], captured on the edge that enters RESP and held valid during RESP.
- Out-of-range request:
  - Same timing as a normal request. No array write. resp_rdata=0, resp_error=1 in RESP.
- Default value: resp_rdata and resp_error return to 0 when not in RESP.
- Reset mid-operation: an asserted rst in WAIT or RESP aborts immediately. No store is committed unless the RESP-entry edge already occurred; the array is then cleared anyway. No resp_valid is emitted after reset releases.
- Load after store to the same word: the second request observes the committed data, because there is only one outstanding request.

Test Plan:
- Reset, then load from address 0x3 with WAIT_STATES=2 -> req_ready drops the cycle after accept; resp_valid is high exactly 3 cycles after the accepting edge; resp_rdata=0x00000000, resp_error=0.
- Store 0xDEADBEEF to address 0x5 with wstrb=4'hF, then load 0x5 -> store response has rdata=0; load returns 0xDEADBEEF; accepts are 4 cycles apart.
- Store 0x11223344 to 0x7 with 4'hF, store 0xAABBCCDD to 0x7 with 4'b0101, then load 0x7 -> 0x11BB33DD.
- Load from address 0x00000010, and separately store 0x12345678 to 0x10 -> resp_error=1 and resp_rdata=0. A subsequent load of 0x0 returns 0, proving no alias write.
- Assert rst during WAIT of a store of 0xCAFEF00D to 0x2, release it, then load 0x2 -> no resp_valid for the aborted store; the load returns 0x00000000.
- WAIT_STATES=0 build, with req_valid held high continuously issuing loads of 0x1 and 0x2 -> resp_valid pulses every 2nd cycle; each response matches the address accepted 1 cycle earlier.
